times_table_lut: RTL and testbench

//  Parametrised A_W x B_W unsigned times-table lookup held in an internal memory.

---
 rtl/times_table_lut.sv | 151 +++++++++++++++
 tb/tb_times_table_lut.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/times_table_lut.sv
// rtl/times_table_lut.sv - A_W x B_W unsigned times-table held in memory, filled by repeated addition
//
// Purpose:
//   After reset an init FSM writes mem[{a,b}] = a*b for every entry, one entry
//   per cycle, using only an accumulator (no multiplier). Once the table is full
//   ready rises and one lookup per cycle is served at a fixed latency.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous active-low reset
//   enable  in   1      lookup request, sampled only while ready=1
//   a       in   A_W    operand a (address MSBs)
//   b       in   B_W    operand b (address LSBs)
//   ready   out  1      table filled, lookups accepted
//   valid   out  1      result carries the product of an accepted request
//   result  out  RES_W  a*b of the accepted request (holds when valid=0)
//
// Configuration:
//   TT_PIPE_OUT_EN  adds an output register stage after the memory read
//                   (latency 2 instead of 1, throughput unchanged).

module times_table_lut #(
  parameter int A_W   = 3,
  parameter int B_W   = 3,
  parameter int RES_W = A_W + B_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             ready,
  output logic             valid,
  output logic [RES_W-1:0] result
);

  localparam int AD_W  = A_W + B_W;
  localparam int DEPTH = 2 ** AD_W;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AD_W-1:0]  r_addr;      // fill counter {ca,cb}, cb is the inner loop
  logic [RES_W-1:0] r_acc;       // value written on the previous fill cycle
  logic [RES_W-1:0] r_mem [DEPTH];
  logic             r_ready;
  logic             r_valid;
  logic [RES_W-1:0] r_result;

  logic [A_W-1:0]   w_ca;
  logic [B_W-1:0]   w_cb;
  logic             w_last;
  logic             w_wr_en;
  logic             w_accept;
  logic [RES_W-1:0] w_wdata;

  assign w_ca = r_addr[AD_W-1:B_W];
  assign w_cb = r_addr[B_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_last      = (r_addr == {AD_W{1'b1}});
    // Each row restarts at 0 and then climbs by ca per column: ca*cb without a multiplier.
    w_wdata     = (w_cb == '0) ? '0 : r_acc + RES_W'(w_ca);
    unique case (r_state)
      S_INIT: begin
        w_wr_en = 1'b1;
        if (w_last) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_addr  <= '0;
      r_acc   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_RUN);
      if (w_wr_en) begin
        r_acc <= w_wdata;
        // Counter freezes on the last address; it never wraps once in RUN.
        if (!w_last) begin
          r_addr <= r_addr + AD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) begin
      r_mem[r_addr] <= w_wdata;
    end
  end

  // ready is only high in RUN, so enable during INIT is dropped here.
  assign w_accept = enable && r_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_result <= r_mem[{a, b}];
      end
    end
  end

`ifdef TT_PIPE_OUT_EN
  logic             r_valid_q;
  logic [RES_W-1:0] r_result_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid_q  <= 1'b0;
      r_result_q <= '0;
    end else begin
      r_valid_q <= r_valid;
      if (r_valid) begin
        r_result_q <= r_result;
      end
    end
  end

  assign valid  = r_valid_q;
  assign result = r_result_q;
`else
  assign valid  = r_valid;
  assign result = r_result;
`endif

  assign ready = r_ready;

endmodule

// File: tb/tb_times_table_lut.sv
// tb/tb_times_table_lut.sv - randomized self-checking bench for times_table_lut
//
// Purpose: drives lookups against a queue-based reference model of the
//   multiply table (plain a*b arithmetic, fixed latency, DEPTH-cycle init).
// Ports: none (top-level bench). Honours TT_PIPE_OUT_EN for latency.

module tb_times_table_lut;

`ifdef TT_PIPE_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 64;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [2:0] a;
  logic [2:0] b;
  logic       ready;
  logic       valid;
  logic [5:0] result;

  int n_vec;
  int n_err;

  // Reference model state
  int         init_cnt;
  logic       exp_ready;
  logic       exp_valid;
  logic [5:0] exp_result;
  logic [6:0] pipe_q[$];

  times_table_lut #(.A_W(3), .B_W(3), .RES_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .valid  (valid),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, advance the reference model across the edge,
  // and leave the bench 1 time unit after the edge for sampling.
  task automatic step(input logic en, input logic [2:0] sa, input logic [2:0] sb);
    int         p;
    logic [6:0] ent;
    enable = en;
    a      = sa;
    b      = sb;
    @(posedge clk);
    if (!rst_n) begin
      init_cnt   = 0;
      exp_ready  = 1'b0;
      exp_valid  = 1'b0;
      exp_result = '0;
      pipe_q.delete();
      for (int k = 0; k < LAT - 1; k++) pipe_q.push_back(7'd0);
    end else begin
      p   = int'(sa) * int'(sb);
      ent = {en && exp_ready, p[5:0]};
      pipe_q.push_back(ent);
      ent = pipe_q.pop_front();
      exp_valid = ent[6];
      if (ent[6]) exp_result = ent[5:0];
      if (init_cnt < DEPTH) init_cnt++;
      exp_ready = (init_cnt == DEPTH);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(0, 0, 0);
    step(1, 3, 3);
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_vec++; if (result !== 6'd0) begin n_err++; $display("FAIL reset_result: got %0d want 0", result); end
  endtask

  // enable held high through the whole fill: nothing may come out until after ready.
  task automatic test_init_ignore();
    logic exp_r;
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 2, 3);
      exp_r = (i == DEPTH);
      n_vec++; if (ready !== exp_r) begin n_err++; $display("FAIL init_ready[%0d]: got %b want %b", i, ready, exp_r); end
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL init_valid[%0d]: got %b want 0", i, valid); end
    end
    step(1, 2, 3);
    repeat (LAT - 1) step(0, 0, 0);
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", valid); end
    n_vec++; if (result !== 6'd6) begin n_err++; $display("FAIL first_result: got %0d want 6", result); end
  endtask

  task automatic test_directed();
    logic [2:0] ta [3] = '{3'd7, 3'd0, 3'd3};
    logic [2:0] tb [3] = '{3'd7, 3'd5, 3'd6};
    logic [5:0] tr [3] = '{6'd49, 6'd0, 6'd18};
    for (int i = 0; i < 3; i++) begin
      step(1, ta[i], tb[i]);
      repeat (LAT - 1) step(0, 0, 0);
      n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL dir_valid[%0d]: got %b want 1", i, valid); end
      n_vec++; if (result !== tr[i]) begin n_err++; $display("FAIL dir_result[%0d]: got %0d want %0d", i, result, tr[i]); end
      step(0, 3'd1, 3'd1);
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 0", i, valid); end
      n_vec++; if (result !== tr[i]) begin n_err++; $display("FAIL hold_result[%0d]: got %0d want %0d", i, result, tr[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int         cnt;
    logic [5:0] idx;
    cnt = 0;
    for (int i = 0; i < DEPTH + LAT; i++) begin
      idx = i[5:0];
      if (i < DEPTH) step(1, idx[5:3], idx[2:0]);
      else           step(0, 0, 0);
      n_vec++; if (valid !== exp_valid) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, valid, exp_valid); end
      n_vec++; if (result !== exp_result) begin n_err++; $display("FAIL b2b_result[%0d]: got %0d want %0d", i, result, exp_result); end
      if (valid === 1'b1) cnt++;
    end
    n_vec++; if (cnt != DEPTH) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", cnt, DEPTH); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom));
      n_vec++; if (ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, ready, exp_ready); end
      n_vec++; if (valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, valid, exp_valid); end
      n_vec++; if (result !== exp_result) begin n_err++; $display("FAIL rnd_result[%0d]: got %0d want %0d", i, result, exp_result); end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_r;
    step(1, 7, 7);
    repeat (LAT - 1) step(1, 3, 3);
    n_vec++; if (result !== 6'd49) begin n_err++; $display("FAIL mid_pre: got %0d want 49", result); end
    rst_n = 1'b0;
    step(1, 4, 4);
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b want 0", ready); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", valid); end
    n_vec++; if (result !== 6'd0) begin n_err++; $display("FAIL mid_result: got %0d want 0", result); end
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'($urandom), 3'($urandom), 3'($urandom));
      exp_r = (i == DEPTH);
      n_vec++; if (ready !== exp_r) begin n_err++; $display("FAIL refill_ready[%0d]: got %b want %b", i, ready, exp_r); end
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL refill_valid[%0d]: got %b want 0", i, valid); end
    end
    step(1, 5, 5);
    repeat (LAT - 1) step(0, 0, 0);
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL post_valid: got %b want 1", valid); end
    n_vec++; if (result !== 6'd25) begin n_err++; $display("FAIL post_result: got %0d want 25", result); end
  endtask

`ifdef TT_PIPE_OUT_EN
  task automatic test_pipe();
    step(1, 6, 7);
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL pipe_early: got %b want 0", valid); end
    step(0, 0, 0);
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL pipe_valid: got %b want 1", valid); end
    n_vec++; if (result !== 6'd42) begin n_err++; $display("FAIL pipe_result: got %0d want 42", result); end
  endtask
`endif

  initial begin
    n_vec      = 0;
    n_err      = 0;
    init_cnt   = 0;
    exp_ready  = 1'b0;
    exp_valid  = 1'b0;
    exp_result = '0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    a          = '0;
    b          = '0;
    test_reset();
    test_init_ignore();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef TT_PIPE_OUT_EN
    test_pipe();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
